axis_uart_rx: RTL and testbench

- Receives asynchronous UART frames on a single serial line and presents each byte as an AXI-Stream master beat.
- Frame format: start bit, 8 data bits LSB first, optional parity, one stop bit.
- Is the receive half of the AXI-Stream UART, alongside the transmitter.
- The register block drives the clock divider and parity controls; the status register consumes the error flags.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/bit_sync.sv | 34 +++
 rtl/axis_uart_rx.sv | 169 ++++++++++++++++
 tb/tb_axis_uart_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, widths and helpers for the AXI-Stream UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int DIVIDER_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        WAIT   = 3'd5
    } uart_state_e;

    typedef struct packed {
        logic [4:0] reserved;
        logic       frame_err;
        logic       parity_err;
        logic       rx_valid;
    } uart_status_reg_t;

    // Expected parity bit: odd makes the total count of ones odd.
    function automatic logic parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// ============================================================================
// Module      : bit_sync
// Description : Two-flop synchronizer for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

`default_nettype wire

// File: rtl/axis_uart_rx.sv
// ============================================================================
// Module      : axis_uart_rx
// Description : UART receiver presenting each received byte as an AXI-Stream beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_uart_rx #(
    parameter int DIVIDER_WIDTH = uart_pkg::DIVIDER_WIDTH,
    parameter int DATA_WIDTH    = uart_pkg::DATA_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic                     parity_odd_i,
    input  logic                     parity_even_i,
    input  logic                     uart_rx_i,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     overrun_err_o
);

    import uart_pkg::*;

    localparam int c_bit_cnt_w = $clog2(DATA_WIDTH);

    logic                     w_rx_s;
    logic [DIVIDER_WIDTH-1:0] w_div_clamped;
    logic [DIVIDER_WIDTH-1:0] w_half_m1;
    logic [DIVIDER_WIDTH-1:0] w_full_m1;

    uart_state_e              r_state;
    logic [DIVIDER_WIDTH-1:0] r_clk_cnt;
    logic [c_bit_cnt_w-1:0]   r_bit_cnt;
    logic [DIVIDER_WIDTH-1:0] r_div;
    logic                     r_par_en;
    logic                     r_par_odd;
    logic                     r_par_flag;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic [DATA_WIDTH-1:0]    r_tdata;
    logic                     r_tvalid;
    logic                     r_parity_err;
    logic                     r_frame_err;
    logic                     r_overrun_err;

    bit_sync #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (uart_rx_i),
        .q_o   (w_rx_s)
    );

    assign w_div_clamped = (clk_divider_i < DIVIDER_WIDTH'(4)) ? DIVIDER_WIDTH'(4) : clk_divider_i;
    assign w_half_m1     = (r_div >> 1) - DIVIDER_WIDTH'(1);
    assign w_full_m1     = r_div - DIVIDER_WIDTH'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_clk_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_div         <= DIVIDER_WIDTH'(4);
            r_par_en      <= 1'b0;
            r_par_odd     <= 1'b0;
            r_par_flag    <= 1'b0;
            r_shift       <= '0;
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            if (r_tvalid && m_axis_tready_i) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    // Divider and parity mode are frozen for the whole frame.
                    if (!w_rx_s) begin
                        r_state    <= START;
                        r_clk_cnt  <= '0;
                        r_div      <= w_div_clamped;
                        r_par_en   <= parity_odd_i | parity_even_i;
                        r_par_odd  <= parity_odd_i;
                        r_par_flag <= 1'b0;
                    end
                end
                START: begin
                    if (r_clk_cnt == w_half_m1) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + DIVIDER_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (r_clk_cnt == w_full_m1) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == c_bit_cnt_w'(DATA_WIDTH - 1)) begin
                            r_state <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_bit_cnt_w'(1);
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + DIVIDER_WIDTH'(1);
                    end
                end
                PARITY: begin
                    if (r_clk_cnt == w_full_m1) begin
                        r_clk_cnt  <= '0;
                        r_par_flag <= (w_rx_s != parity(r_shift, r_par_odd));
                        r_state    <= STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + DIVIDER_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (r_clk_cnt == w_full_m1) begin
                        r_clk_cnt <= '0;
                        if (w_rx_s) begin
                            // Straight to IDLE so a start bit right after the stop is caught.
                            r_state <= IDLE;
                            if (!r_tvalid || m_axis_tready_i) begin
                                r_tdata      <= r_shift;
                                r_tvalid     <= 1'b1;
                                r_parity_err <= r_par_flag;
                            end else begin
                                r_overrun_err <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + DIVIDER_WIDTH'(1);
                    end
                end
                WAIT: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata_o  = r_tdata;
    assign m_axis_tvalid_o = r_tvalid;
    assign parity_err_o    = r_parity_err;
    assign frame_err_o     = r_frame_err;
    assign overrun_err_o   = r_overrun_err;

endmodule

`default_nettype wire

// File: tb/tb_axis_uart_rx.sv
// ============================================================================
// Module      : tb_axis_uart_rx
// Description : Directed self-checking bench for axis_uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_uart_rx;

    import uart_pkg::*;

    localparam int N = 16;
    // Pin fall to first negedge with tvalid: 2 sync + 1 IDLE detect + N/2 + 9N + 1 register.
    localparam int c_basic_latency = 2 + 1 + N / 2 + 9 * N + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clk_divider = 32'd16;
    logic        parity_odd = 1'b0;
    logic        parity_even = 1'b0;
    logic        uart_rx = 1'b1;
    logic        tready = 1'b1;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        perr;
    logic        ferr;
    logic        ovr;

    int tests = 0;
    int fails = 0;

    int         neg_cnt = 0;
    int         rise_neg = 0;
    int         beats = 0;
    int         valid_cycles = 0;
    int         perr_cnt = 0;
    int         perr_v_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic       prev_valid = 1'b0;

    axis_uart_rx dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clk_divider_i   (clk_divider),
        .parity_odd_i    (parity_odd),
        .parity_even_i   (parity_even),
        .uart_rx_i       (uart_rx),
        .m_axis_tdata_o  (tdata),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tready_i (tready),
        .parity_err_o    (perr),
        .frame_err_o     (ferr),
        .overrun_err_o   (ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        neg_cnt    <= neg_cnt + 1;
        prev_valid <= tvalid;
        if (tvalid && !prev_valid) rise_neg <= neg_cnt + 1;
        if (tvalid) valid_cycles <= valid_cycles + 1;
        if (tvalid && tready) begin
            beats     <= beats + 1;
            last_data <= tdata;
        end
        if (perr) perr_cnt <= perr_cnt + 1;
        if (perr && tvalid) perr_v_cnt <= perr_v_cnt + 1;
        if (ferr) ferr_cnt <= ferr_cnt + 1;
        if (ovr) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic drive_bit(input logic b, input int n);
        uart_rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int n, input bit par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(data[i], n);
        if (par_en) drive_bit(par_bit, n);
        drive_bit(stop_bit, n);
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b, expected 0", tvalid); end
        tests++; if (tdata !== 8'h00) begin fails++; $display("FAIL reset_tdata: got %h, expected 00", tdata); end
        tests++; if ({perr, ferr, ovr} !== 3'b000) begin fails++; $display("FAIL reset_errors: got %b, expected 000", {perr, ferr, ovr}); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_basic;
        int s, b0, v0, e0;
        s = neg_cnt; b0 = beats; v0 = valid_cycles; e0 = perr_cnt + ferr_cnt + ovr_cnt;
        send_frame(8'hA5, N, 0, 1'b0, 1'b1);
        idle(4);
        tests++; if (rise_neg - s !== c_basic_latency) begin fails++; $display("FAIL basic_latency: got %0d, expected %0d", rise_neg - s, c_basic_latency); end
        tests++; if (beats - b0 !== 1) begin fails++; $display("FAIL basic_beats: got %0d, expected 1", beats - b0); end
        tests++; if (last_data !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h, expected a5", last_data); end
        tests++; if (valid_cycles - v0 !== 1) begin fails++; $display("FAIL basic_valid_cycles: got %0d, expected 1", valid_cycles - v0); end
        tests++; if (perr_cnt + ferr_cnt + ovr_cnt - e0 !== 0) begin fails++; $display("FAIL basic_errors: got %0d, expected 0", perr_cnt + ferr_cnt + ovr_cnt - e0); end
    endtask

    task automatic test_parity;
        int b0, p0, pv0;
        // Even parity, 0x03 has even weight so the correct bit is 0; send 1.
        parity_even = 1'b1; parity_odd = 1'b0;
        b0 = beats; p0 = perr_cnt; pv0 = perr_v_cnt;
        send_frame(8'h03, N, 1, 1'b1, 1'b1);
        idle(4);
        tests++; if (beats - b0 !== 1 || last_data !== 8'h03) begin fails++; $display("FAIL even_data: got %0d beats data %h, expected 1 beat data 03", beats - b0, last_data); end
        tests++; if (perr_v_cnt - pv0 !== 1 || perr_cnt - p0 !== 1) begin fails++; $display("FAIL even_perr: got %0d with tvalid %0d total, expected 1 1", perr_v_cnt - pv0, perr_cnt - p0); end
        // Odd parity, correct bit for 0x03 is 1.
        parity_even = 1'b0; parity_odd = 1'b1;
        b0 = beats; p0 = perr_cnt;
        send_frame(8'h03, N, 1, 1'b1, 1'b1);
        idle(4);
        tests++; if (beats - b0 !== 1 || last_data !== 8'h03) begin fails++; $display("FAIL odd_data: got %0d beats data %h, expected 1 beat data 03", beats - b0, last_data); end
        tests++; if (perr_cnt - p0 !== 0) begin fails++; $display("FAIL odd_perr: got %0d, expected 0", perr_cnt - p0); end
        // Both enables set: odd wins, so bit 1 is still correct.
        parity_even = 1'b1;
        p0 = perr_cnt;
        send_frame(8'h03, N, 1, 1'b1, 1'b1);
        idle(4);
        tests++; if (perr_cnt - p0 !== 0) begin fails++; $display("FAIL both_perr: got %0d, expected 0", perr_cnt - p0); end
        parity_even = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_glitch;
        int b0, e0;
        b0 = beats; e0 = perr_cnt + ferr_cnt + ovr_cnt;
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(40);
        tests++; if (beats - b0 !== 0 || perr_cnt + ferr_cnt + ovr_cnt - e0 !== 0) begin fails++; $display("FAIL glitch_quiet: got %0d beats %0d errors, expected 0 0", beats - b0, perr_cnt + ferr_cnt + ovr_cnt - e0); end
        tests++; if (dut.r_state !== IDLE) begin fails++; $display("FAIL glitch_state: got %0d, expected %0d", dut.r_state, IDLE); end
        send_frame(8'h5A, N, 0, 1'b0, 1'b1);
        idle(4);
        tests++; if (beats - b0 !== 1 || last_data !== 8'h5A) begin fails++; $display("FAIL glitch_next: got %0d beats data %h, expected 1 beat data 5a", beats - b0, last_data); end
    endtask

    task automatic test_frame_err;
        int b0, f0, v0;
        b0 = beats; f0 = ferr_cnt; v0 = valid_cycles;
        send_frame(8'h7E, N, 0, 1'b0, 1'b0);
        uart_rx = 1'b0;
        repeat (40 * N) @(posedge clk);
        #1;
        tests++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_pulse: got %0d, expected 1", ferr_cnt - f0); end
        tests++; if (valid_cycles - v0 !== 0) begin fails++; $display("FAIL ferr_no_valid: got %0d, expected 0", valid_cycles - v0); end
        idle(2 * N);
        send_frame(8'h11, N, 0, 1'b0, 1'b1);
        idle(4);
        tests++; if (beats - b0 !== 1 || last_data !== 8'h11) begin fails++; $display("FAIL ferr_next: got %0d beats data %h, expected 1 beat data 11", beats - b0, last_data); end
        tests++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_once: got %0d, expected 1", ferr_cnt - f0); end
    endtask

    task automatic test_overrun;
        int b0, o0;
        tready = 1'b0;
        b0 = beats; o0 = ovr_cnt;
        send_frame(8'h11, N, 0, 1'b0, 1'b1);
        send_frame(8'h22, N, 0, 1'b0, 1'b1);
        idle(4);
        tests++; if (tvalid !== 1'b1 || tdata !== 8'h11) begin fails++; $display("FAIL ovr_hold: got tvalid %b tdata %h, expected 1 11", tvalid, tdata); end
        tests++; if (ovr_cnt - o0 !== 1) begin fails++; $display("FAIL ovr_pulse: got %0d, expected 1", ovr_cnt - o0); end
        tready = 1'b1;
        idle(3);
        tests++; if (beats - b0 !== 1 || last_data !== 8'h11) begin fails++; $display("FAIL ovr_drain: got %0d beats data %h, expected 1 beat data 11", beats - b0, last_data); end
        tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL ovr_tvalid_drop: got %b, expected 0", tvalid); end
    endtask

    task automatic test_min_divider;
        int b0;
        clk_divider = 32'd2;
        b0 = beats;
        send_frame(8'h96, 4, 0, 1'b0, 1'b1);
        idle(8);
        tests++; if (beats - b0 !== 1 || last_data !== 8'h96) begin fails++; $display("FAIL min_div: got %0d beats data %h, expected 1 beat data 96", beats - b0, last_data); end
        clk_divider = 32'd16;
    endtask

    task automatic test_reset_mid;
        int b0, v0;
        b0 = beats;
        fork
            send_frame(8'hE5, N, 0, 1'b0, 1'b1);
            begin
                v0 = 0;
                // Bit 4 occupies pin cycles 80..95 of the frame.
                repeat (84) @(posedge clk);
                #1;
                rst = 1'b1;
                @(negedge clk);
                v0 = valid_cycles;
                tests++; if (tvalid !== 1'b0 || tdata !== 8'h00) begin fails++; $display("FAIL mid_reset_outputs: got tvalid %b tdata %h, expected 0 00", tvalid, tdata); end
                repeat (16) @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        idle(4 * N);
        tests++; if (beats - b0 !== 0 || valid_cycles - v0 !== 0) begin fails++; $display("FAIL mid_no_output: got %0d beats %0d valid cycles, expected 0 0", beats - b0, valid_cycles - v0); end
        send_frame(8'hC3, N, 0, 1'b0, 1'b1);
        idle(4);
        tests++; if (beats - b0 !== 1 || last_data !== 8'hC3) begin fails++; $display("FAIL mid_next: got %0d beats data %h, expected 1 beat data c3", beats - b0, last_data); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_min_divider;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
